// File: rtl/tlp_xcvr_pkg.sv
// Shared sizing and types for the F2C (FPGA-to-CPU) chunk producer.
package tlp_xcvr_pkg;

  localparam int unsigned F2C_CHUNKSIZE = 128;
  localparam int unsigned F2C_NUMCHUNKS = 4;
  localparam int unsigned F2C_QWS       = F2C_CHUNKSIZE / 8;

  typedef logic [31:0] uint32;
  typedef logic [63:0] uint64;

  typedef logic [$clog2(F2C_NUMCHUNKS)-1:0] F2CChunkIndex;
  typedef logic [$clog2(F2C_QWS)-1:0]       F2CChunkOffset;
  typedef logic [$bits(F2CChunkIndex)+$bits(F2CChunkOffset)-1:0] F2CQwAddr;

  function automatic F2CChunkIndex f2c_next_index(input F2CChunkIndex idx);
    return (idx == F2CChunkIndex'(F2C_NUMCHUNKS - 1)) ? '0 : idx + F2CChunkIndex'(1);
  endfunction

endpackage

// File: rtl/f2c_producer_if.sv
// Bundle of the producer's chunk-RAM write bus, checksum and host-side index signals.
interface f2c_producer_if;

  tlp_xcvr_pkg::F2CChunkIndex wr_index;
  tlp_xcvr_pkg::F2CChunkIndex rd_index;
  logic                       wr_enable;
  tlp_xcvr_pkg::F2CQwAddr     wr_addr;
  tlp_xcvr_pkg::uint64        wr_data;
  tlp_xcvr_pkg::uint64        cs_data;
  logic                       cs_reset;
  tlp_xcvr_pkg::uint32        count_init;

  modport master (
    output wr_index, wr_enable, wr_addr, wr_data, cs_data,
    input  rd_index, cs_reset, count_init
  );

  modport slave (
    input  wr_index, wr_enable, wr_addr, wr_data, cs_data,
    output rd_index, cs_reset, count_init
  );

endinterface

// File: rtl/f2c_producer.sv
// Fills a ring of fixed-size chunks with an incrementing 64-bit pattern, keeping one
// slot free, throttling between chunks and accumulating a running checksum.
module f2c_producer
  import tlp_xcvr_pkg::*;
(
  input  logic         sysClk_in,
  input  logic         sysRstN_in,
  output F2CChunkIndex wrIndex_out,
  input  F2CChunkIndex rdIndex_in,
  output logic         wrEnable_out,
  output F2CQwAddr     wrAddr_out,
  output uint64        wrData_out,
  output uint64        csData_out,
  input  logic         csReset_in,
  input  uint32        countInit_in
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COMMIT, S_WAIT} state_t;

  state_t        state, state_next;
  F2CChunkIndex  wr_index, wr_index_next;
  F2CChunkOffset offset, offset_next;
  uint64         data_count, data_count_next;
  uint64         ck_sum, ck_sum_next;
  uint32         count, count_next;
  logic          full;

  assign full = (f2c_next_index(wr_index) == rdIndex_in);

  always_ff @(posedge sysClk_in) begin
    if (!sysRstN_in) begin
      state      <= S_IDLE;
      wr_index   <= '0;
      offset     <= '0;
      data_count <= '0;
      ck_sum     <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      wr_index   <= wr_index_next;
      offset     <= offset_next;
      data_count <= data_count_next;
      ck_sum     <= ck_sum_next;
      count      <= count_next;
    end
  end

  always_comb begin
    state_next      = state;
    wr_index_next   = wr_index;
    offset_next     = offset;
    data_count_next = data_count;
    count_next      = count;
    wrEnable_out    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (countInit_in != '0 && !full) begin
          state_next  = S_WRITE;
          offset_next = '0;
        end
      end
      S_WRITE: begin
        wrEnable_out    = 1'b1;
        offset_next     = offset + F2CChunkOffset'(1);
        data_count_next = data_count + 64'd1;
        if (offset == F2CChunkOffset'(F2C_QWS - 1)) begin
          state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Index advances only after the whole chunk is already in RAM.
        wr_index_next = f2c_next_index(wr_index);
        count_next    = countInit_in - 32'd1;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        if (count == '0) begin
          state_next = S_IDLE;
        end else begin
          count_next = count - 32'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    ck_sum_next = (csReset_in ? '0 : ck_sum) + (wrEnable_out ? data_count : '0);
  end

  assign wrIndex_out = wr_index;
  assign wrAddr_out  = {wr_index, offset};
  assign wrData_out  = data_count;
  assign csData_out  = ck_sum;

endmodule

// File: tb/tb_f2c_producer.sv
// Directed bench for f2c_producer: chunk writes, ring fill/wrap, throttle gap,
// disable, checksum clear and mid-chunk reset.
module tb_f2c_producer;
  import tlp_xcvr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  f2c_producer_if bus ();

  f2c_producer dut (
    .sysClk_in    (clk),
    .sysRstN_in   (rst_n),
    .wrIndex_out  (bus.wr_index),
    .rdIndex_in   (bus.rd_index),
    .wrEnable_out (bus.wr_enable),
    .wrAddr_out   (bus.wr_addr),
    .wrData_out   (bus.wr_data),
    .csData_out   (bus.cs_data),
    .csReset_in   (bus.cs_reset),
    .countInit_in (bus.count_init)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input uint32 ci, input F2CChunkIndex rd);
    rst_n          = 1'b0;
    bus.count_init = ci;
    bus.rd_index   = rd;
    bus.cs_reset   = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_write(input int unsigned budget, output bit found);
    found = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      if (bus.wr_enable === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.count_init = 32'd4;
    bus.rd_index   = '0;
    bus.cs_reset   = 1'b0;
    step(2);
    vectors++;
    if (bus.wr_enable !== 1'b0) begin
      miscompares++; $display("FAIL reset_wr_enable: got %b expected 0", bus.wr_enable);
    end
    vectors++;
    if (bus.wr_index !== F2CChunkIndex'(0)) begin
      miscompares++; $display("FAIL reset_wr_index: got %0d expected 0", bus.wr_index);
    end
    vectors++;
    if (bus.cs_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_cs_data: got %0d expected 0", bus.cs_data);
    end
    vectors++;
    if (bus.wr_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_wr_data: got %0d expected 0", bus.wr_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_chunk();
    bit       found;
    F2CQwAddr exp_addr;
    apply_reset(32'd4, '0);
    wait_write(4, found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL first_start: got no write expected write within 4 cycles");
    end
    for (int unsigned i = 0; i < F2C_QWS; i++) begin
      exp_addr = {F2CChunkIndex'(0), F2CChunkOffset'(i)};
      vectors++;
      if (bus.wr_enable !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== 64'(i)) begin
        miscompares++;
        $display("FAIL first_qw%0d: got en=%b addr=%h data=%0d expected en=1 addr=%h data=%0d",
                 i, bus.wr_enable, bus.wr_addr, bus.wr_data, exp_addr, i);
      end
      step();
    end
    vectors++;
    if (bus.wr_enable !== 1'b0 || bus.wr_index !== F2CChunkIndex'(0)) begin
      miscompares++;
      $display("FAIL first_commit: got en=%b idx=%0d expected en=0 idx=0", bus.wr_enable, bus.wr_index);
    end
    step();
    vectors++;
    if (bus.wr_index !== F2CChunkIndex'(1)) begin
      miscompares++; $display("FAIL first_index: got %0d expected 1", bus.wr_index);
    end
    vectors++;
    if (bus.cs_data !== 64'd120) begin
      miscompares++; $display("FAIL first_cksum: got %0d expected 120", bus.cs_data);
    end
  endtask

  task automatic test_fill_and_wrap();
    bit          found;
    F2CQwAddr    exp_addr;
    int unsigned stray;
    apply_reset(32'd1, '0);
    for (int unsigned c = 0; c < 3; c++) begin
      wait_write(20, found);
      vectors++;
      if (!found) begin
        miscompares++; $display("FAIL fill_start%0d: got no write expected write", c);
      end
      for (int unsigned i = 0; i < F2C_QWS; i++) begin
        exp_addr = {F2CChunkIndex'(c), F2CChunkOffset'(i)};
        vectors++;
        if (bus.wr_enable !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== 64'(c * 16 + i)) begin
          miscompares++;
          $display("FAIL fill_c%0d_qw%0d: got en=%b addr=%h data=%0d expected en=1 addr=%h data=%0d",
                   c, i, bus.wr_enable, bus.wr_addr, bus.wr_data, exp_addr, c * 16 + i);
        end
        step();
      end
    end
    step();
    stray = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      if (bus.wr_enable !== 1'b0) stray++;
      step();
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL full_stall: got %0d write cycles expected 0", stray);
    end
    vectors++;
    if (bus.wr_index !== F2CChunkIndex'(3)) begin
      miscompares++; $display("FAIL full_index: got %0d expected 3", bus.wr_index);
    end
    bus.rd_index = F2CChunkIndex'(1);
    wait_write(10, found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL wrap_start: got no write expected write");
    end
    for (int unsigned i = 0; i < F2C_QWS; i++) begin
      exp_addr = {F2CChunkIndex'(3), F2CChunkOffset'(i)};
      vectors++;
      if (bus.wr_enable !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== 64'(48 + i)) begin
        miscompares++;
        $display("FAIL wrap_qw%0d: got en=%b addr=%h data=%0d expected en=1 addr=%h data=%0d",
                 i, bus.wr_enable, bus.wr_addr, bus.wr_data, exp_addr, 48 + i);
      end
      step();
    end
    step();
    vectors++;
    if (bus.wr_index !== F2CChunkIndex'(0)) begin
      miscompares++; $display("FAIL wrap_index: got %0d expected 0", bus.wr_index);
    end
    stray = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (bus.wr_enable !== 1'b0) stray++;
      step();
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL wrap_full_stall: got %0d write cycles expected 0", stray);
    end
  endtask

  task automatic test_gap();
    bit          found;
    int unsigned gap;
    F2CQwAddr    exp_addr;
    apply_reset(32'd3, '0);
    wait_write(4, found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL gap_start: got no write expected write");
    end
    step(F2C_QWS);
    gap = 0;
    while (bus.wr_enable !== 1'b1 && gap < 50) begin
      gap++;
      step();
    end
    vectors++;
    if (gap != 5) begin
      miscompares++; $display("FAIL gap_ci3: got %0d idle cycles expected 5", gap);
    end
    // Raising the throttle mid-chunk must not cut the chunk short; it is picked up at commit.
    for (int unsigned i = 0; i < F2C_QWS; i++) begin
      if (i == 8) bus.count_init = 32'd7;
      exp_addr = {F2CChunkIndex'(1), F2CChunkOffset'(i)};
      vectors++;
      if (bus.wr_enable !== 1'b1 || bus.wr_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL gap_c1_qw%0d: got en=%b addr=%h expected en=1 addr=%h",
                 i, bus.wr_enable, bus.wr_addr, exp_addr);
      end
      step();
    end
    gap = 0;
    while (bus.wr_enable !== 1'b1 && gap < 50) begin
      gap++;
      step();
    end
    vectors++;
    if (gap != 9) begin
      miscompares++; $display("FAIL gap_ci7: got %0d idle cycles expected 9", gap);
    end
    vectors++;
    if (bus.wr_addr !== {F2CChunkIndex'(2), F2CChunkOffset'(0)} || bus.wr_data !== 64'd32) begin
      miscompares++;
      $display("FAIL gap_c2_first: got addr=%h data=%0d expected addr=20 data=32", bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_disabled();
    int unsigned stray;
    apply_reset(32'd0, '0);
    stray = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (bus.wr_enable !== 1'b0) stray++;
      step();
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL disabled: got %0d write cycles expected 0", stray);
    end
    bus.count_init = 32'd2;
    step();
    vectors++;
    if (bus.wr_enable !== 1'b1 || bus.wr_addr !== F2CQwAddr'(0) || bus.wr_data !== 64'd0) begin
      miscompares++;
      $display("FAIL enable_start: got en=%b addr=%h data=%0d expected en=1 addr=0 data=0",
               bus.wr_enable, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_cs_reset();
    bit found;
    apply_reset(32'd4, '0);
    wait_write(4, found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL cs_start: got no write expected write");
    end
    for (int unsigned i = 0; i < F2C_QWS; i++) begin
      bus.cs_reset = (i == 5);
      step();
    end
    bus.cs_reset = 1'b0;
    vectors++;
    if (bus.cs_data !== 64'd110) begin
      miscompares++; $display("FAIL cs_clear_in_write: got %0d expected 110", bus.cs_data);
    end
    bus.cs_reset = 1'b1;
    step();
    bus.cs_reset = 1'b0;
    vectors++;
    if (bus.cs_data !== 64'd0) begin
      miscompares++; $display("FAIL cs_clear_idle: got %0d expected 0", bus.cs_data);
    end
    wait_write(20, found);
    step();
    vectors++;
    if (!found || bus.cs_data !== 64'd16) begin
      miscompares++; $display("FAIL cs_resume: got found=%b sum=%0d expected found=1 sum=16", found, bus.cs_data);
    end
  endtask

  task automatic test_mid_reset();
    bit       found;
    F2CQwAddr exp_addr;
    apply_reset(32'd4, '0);
    wait_write(4, found);
    step(7);
    vectors++;
    if (!found || bus.wr_addr !== {F2CChunkIndex'(0), F2CChunkOffset'(7)} || bus.wr_data !== 64'd7) begin
      miscompares++;
      $display("FAIL midrst_pos: got addr=%h data=%0d expected addr=07 data=7", bus.wr_addr, bus.wr_data);
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if (bus.wr_enable !== 1'b0 || bus.wr_index !== F2CChunkIndex'(0)) begin
      miscompares++;
      $display("FAIL midrst_abort: got en=%b idx=%0d expected en=0 idx=0", bus.wr_enable, bus.wr_index);
    end
    rst_n = 1'b1;
    wait_write(4, found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL midrst_restart: got no write expected write");
    end
    for (int unsigned i = 0; i < F2C_QWS; i++) begin
      exp_addr = {F2CChunkIndex'(0), F2CChunkOffset'(i)};
      vectors++;
      if (bus.wr_enable !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== 64'(i)) begin
        miscompares++;
        $display("FAIL midrst_qw%0d: got en=%b addr=%h data=%0d expected en=1 addr=%h data=%0d",
                 i, bus.wr_enable, bus.wr_addr, bus.wr_data, exp_addr, i);
      end
      step();
    end
    step();
    vectors++;
    if (bus.wr_index !== F2CChunkIndex'(1)) begin
      miscompares++; $display("FAIL midrst_index: got %0d expected 1", bus.wr_index);
    end
  endtask

  initial begin
    test_reset();
    test_first_chunk();
    test_fill_and_wrap();
    test_gap();
    test_disabled();
    test_cs_reset();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
